// File: rtl/jk_bank_driver_if.sv
// -----------------------------------------------------------------------------
// jk_bank_driver_if
//   Request channel into jk_bank_driver: a target word and a mode, transferred
//   on a valid/ready handshake.
//
//   req_valid   requester -> driver   request present
//   req_ready   driver -> requester   driver can accept (idle)
//   req_target  requester -> driver   desired final Q of the bank
//   req_mode    requester -> driver   00 load, 01 step up, 10 step down,
//                                     11 verify only
// -----------------------------------------------------------------------------
interface jk_bank_driver_if #(
    parameter int WIDTH = 4
);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_target;
    logic [1:0]       req_mode;

    modport master (
        output req_valid,
        output req_target,
        output req_mode,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_target,
        input  req_mode,
        output req_ready
    );
endinterface

// File: rtl/jk_bank_driver.sv
// -----------------------------------------------------------------------------
// jk_bank_driver
//   Excitation-side driver for a bank of WIDTH JK flip-flops. It accepts a
//   target word, moves the bank towards it either in one cycle (load) or one
//   count per step (up/down, wrapping), reads Q back after every move and
//   flags any mismatch.
//
//   Parameters
//     WIDTH       bits in the driven JK bank
//     DC_FILL     value driven on J/K inputs whose value does not matter
//
//   Ports
//     CLK         clock, all state updates on posedge
//     reset       synchronous active-low reset
//     req         request channel (slave side)
//     q_in        current Q of the JK bank
//     j_out/k_out J/K inputs to the bank (non-zero only while driving)
//     busy        operation in progress
//     done        one-cycle pulse after an operation completes
//     err         sticky readback mismatch, cleared by the next request
//     step_count  drive steps that changed the bank in the last/current op
// -----------------------------------------------------------------------------
module jk_bank_driver #(
    parameter int WIDTH   = 4,
    parameter bit DC_FILL = 1'b0
) (
    input  logic             CLK,
    input  logic             reset,
    jk_bank_driver_if.slave  req,
    input  logic [WIDTH-1:0] q_in,
    output logic [WIDTH-1:0] j_out,
    output logic [WIDTH-1:0] k_out,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] step_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_CHECK
    } state_e;

    typedef enum logic [1:0] {
        MODE_LOAD   = 2'b00,
        MODE_UP     = 2'b01,
        MODE_DOWN   = 2'b10,
        MODE_VERIFY = 2'b11
    } mode_e;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_e           state;
    state_e           state_next;
    mode_e            mode_r;
    logic [WIDTH-1:0] target_r;
    logic [WIDTH-1:0] expected_r;
    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] j_drive;
    logic [WIDTH-1:0] k_drive;
    logic             accept;
    logic             check_ok;
    logic             finish;

    assign accept        = (state == S_IDLE) && req.req_valid;
    assign req.req_ready = (state == S_IDLE);
    assign busy          = (state != S_IDLE);

    // Verify mode never drives, so it checks against the latched target;
    // every other mode checks against what the last DRIVE asked for.
    assign check_ok = (q_in == ((mode_r == MODE_VERIFY) ? target_r : expected_r));

    // Value the bank should hold after this DRIVE cycle. Step modes freeze
    // once Q already equals the target; +/- wrap naturally at WIDTH bits.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and a latch cannot be inferred.
        nxt = q_in;
        case (mode_r)
            MODE_LOAD: nxt = target_r;
            MODE_UP:   if (q_in != target_r) nxt = q_in + ONE;
            MODE_DOWN: if (q_in != target_r) nxt = q_in - ONE;
            default:   nxt = q_in;
        endcase
    end

    // Per-bit JK excitation. With DC_FILL the don't-care input of each
    // transition is driven 1 instead of 0.
    generate
        if (DC_FILL) begin : g_fill_one
            assign j_drive = q_in | nxt;
            assign k_drive = ~(q_in & nxt);
        end else begin : g_fill_zero
            assign j_drive = ~q_in & nxt;
            assign k_drive = q_in & ~nxt;
        end
    endgenerate

    // The bank holds (J=K=0) in every state except DRIVE.
    assign j_out = (state == S_DRIVE) ? j_drive : '0;
    assign k_out = (state == S_DRIVE) ? k_drive : '0;

    always_comb begin
        state_next = state;
        finish     = 1'b0;
        case (state)
            S_IDLE: begin
                if (req.req_valid) begin
                    state_next = (mode_e'(req.req_mode) == MODE_VERIFY) ? S_CHECK : S_DRIVE;
                end
            end
            S_DRIVE: state_next = S_CHECK;
            S_CHECK: begin
                if (!check_ok || mode_r == MODE_LOAD || mode_r == MODE_VERIFY
                    || expected_r == target_r) begin
                    state_next = S_IDLE;
                    finish     = 1'b1;
                end else begin
                    state_next = S_DRIVE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Control state: everything visible after reset is cleared here.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!reset) begin
            state      <= S_IDLE;
            done       <= 1'b0;
            err        <= 1'b0;
            step_count <= '0;
        end else begin
            state <= state_next;
            done  <= finish;
            if (accept) begin
                err        <= 1'b0;
                step_count <= '0;
            end
            if (state == S_CHECK && !check_ok) begin
                err <= 1'b1;
            end
            if (state == S_DRIVE && nxt != q_in) begin
                step_count <= step_count + ONE;
            end
        end
    end

    // NOTE: request/datapath registers carry no reset; they are always
    // written on acceptance or in DRIVE before anything reads them.
    always_ff @(posedge CLK) begin
        if (accept) begin
            target_r <= req.req_target;
            mode_r   <= mode_e'(req.req_mode);
        end
        if (state == S_DRIVE) begin
            expected_r <= nxt;
        end
    end

endmodule

// File: tb/tb_jk_bank_driver.sv
// -----------------------------------------------------------------------------
// tb_jk_bank_driver
//   Two driver instances (DC_FILL 0 and 1) fed with the same requests, each in
//   front of its own behavioural JK bank. A reference model predicts, per
//   request, the sequence of bank moves, latency, step count and error flag.
// -----------------------------------------------------------------------------
module tb_jk_bank_driver;
    localparam int WIDTH = 4;
    localparam int N_DUT = 2;
    localparam logic [1:0] M_LOAD   = 2'b00;
    localparam logic [1:0] M_UP     = 2'b01;
    localparam logic [1:0] M_DOWN   = 2'b10;
    localparam logic [1:0] M_VERIFY = 2'b11;

    logic CLK = 1'b0;
    logic reset;
    always #5 CLK = ~CLK;

    jk_bank_driver_if #(.WIDTH(WIDTH)) bus0 ();
    jk_bank_driver_if #(.WIDTH(WIDTH)) bus1 ();

    logic [WIDTH-1:0] q_bank [N_DUT];
    logic [WIDTH-1:0] j_o    [N_DUT];
    logic [WIDTH-1:0] k_o    [N_DUT];
    logic [WIDTH-1:0] sc_o   [N_DUT];
    logic             busy_o [N_DUT];
    logic             done_o [N_DUT];
    logic             err_o  [N_DUT];
    logic             rdy_o  [N_DUT];

    logic [WIDTH-1:0] stuck0;
    logic             preset_en;
    logic [WIDTH-1:0] preset_val;
    logic [WIDTH-1:0] model_q;

    assign rdy_o[0] = bus0.req_ready;
    assign rdy_o[1] = bus1.req_ready;

    jk_bank_driver #(.WIDTH(WIDTH), .DC_FILL(1'b0)) dut0 (
        .CLK(CLK), .reset(reset), .req(bus0), .q_in(q_bank[0]),
        .j_out(j_o[0]), .k_out(k_o[0]), .busy(busy_o[0]), .done(done_o[0]),
        .err(err_o[0]), .step_count(sc_o[0])
    );

    jk_bank_driver #(.WIDTH(WIDTH), .DC_FILL(1'b1)) dut1 (
        .CLK(CLK), .reset(reset), .req(bus1), .q_in(q_bank[1]),
        .j_out(j_o[1]), .k_out(k_o[1]), .busy(busy_o[1]), .done(done_o[1]),
        .err(err_o[1]), .step_count(sc_o[1])
    );

    // Behavioural JK banks: 00 hold, 10 set, 01 clear, 11 toggle, with
    // optional stuck-at-0 bits and a preset path for test setup.
    always @(posedge CLK) begin
        for (int b = 0; b < N_DUT; b++) begin
            if (preset_en) q_bank[b] <= preset_val & ~stuck0;
            else           q_bank[b] <= ((j_o[b] & ~q_bank[b]) | (~k_o[b] & q_bank[b])) & ~stuck0;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_req(input logic v, input logic [WIDTH-1:0] t, input logic [1:0] m);
        bus0.req_valid = v; bus0.req_target = t; bus0.req_mode = m;
        bus1.req_valid = v; bus1.req_target = t; bus1.req_mode = m;
    endtask

    // JK excitation table; the don't-care input takes the fill value.
    function automatic void excite(input logic [WIDTH-1:0] from_v, input logic [WIDTH-1:0] to_v,
                                   input logic fill, output logic [WIDTH-1:0] j, output logic [WIDTH-1:0] k);
        for (int i = 0; i < WIDTH; i++) begin
            case ({from_v[i], to_v[i]})
                2'b00:   begin j[i] = 1'b0; k[i] = fill; end
                2'b01:   begin j[i] = 1'b1; k[i] = fill; end
                2'b10:   begin j[i] = fill; k[i] = 1'b1; end
                default: begin j[i] = fill; k[i] = 1'b0; end
            endcase
        end
    endfunction

    // Called just after a negedge with the drivers idle.
    task automatic preset(input logic [WIDTH-1:0] v);
        preset_en  = 1'b1;
        preset_val = v;
        @(negedge CLK);
        preset_en  = 1'b0;
        model_q    = v & ~stuck0;
    endtask

    // Issues one request and checks every cycle until the done cycle.
    // Returns at the negedge of the done cycle so the next request is
    // presented while done is high.
    task automatic run_op(input logic [1:0] mode, input logic [WIDTH-1:0] target);
        logic [WIDTH-1:0] from_q[$];
        logic [WIDTH-1:0] to_q[$];
        logic [WIDTH-1:0] q0, cur, nx, diff, q_final, ej, ek;
        int   n, lat, exp_sc, idx;
        logic exp_err;

        q0 = model_q;
        n  = 0;
        case (mode)
            M_LOAD: begin
                from_q.push_back(q0); to_q.push_back(target);
                lat = 2; exp_sc = (q0 != target) ? 1 : 0;
                q_final = target & ~stuck0;
            end
            M_VERIFY: begin
                lat = 1; exp_sc = 0; q_final = q0;
            end
            default: begin
                diff = (mode == M_UP) ? target - q0 : q0 - target;
                n    = int'(diff);
                if (n == 0) begin
                    from_q.push_back(q0); to_q.push_back(q0);
                    lat = 2;
                end else begin
                    cur = q0;
                    for (int i = 0; i < n; i++) begin
                        nx = (mode == M_UP) ? cur + WIDTH'(1) : cur - WIDTH'(1);
                        from_q.push_back(cur); to_q.push_back(nx);
                        cur = nx;
                    end
                    lat = 2 * n;
                end
                exp_sc  = n;
                q_final = target;
            end
        endcase
        exp_err = (mode == M_VERIFY) ? (q0 != target) : (q_final != target);

        for (int b = 0; b < N_DUT; b++) check($sformatf("ready_before[%0d]", b), 32'(rdy_o[b]), 32'd1);
        drive_req(1'b1, target, mode);
        @(posedge CLK);
        @(negedge CLK);
        for (int k = 1; k <= lat + 1; k++) begin
            for (int b = 0; b < N_DUT; b++) begin
                check($sformatf("done[%0d]@%0d", b, k), 32'(done_o[b]), 32'(k == lat + 1));
                check($sformatf("busy[%0d]@%0d", b, k), 32'(busy_o[b]), 32'(k <= lat));
                if (k <= lat) begin
                    ej = '0; ek = '0;
                    idx = (k - 1) / 2;
                    if (mode != M_VERIFY && (k % 2) == 1 && idx < from_q.size())
                        excite(from_q[idx], to_q[idx], (b == 1), ej, ek);
                    check($sformatf("j_out[%0d]@%0d", b, k), 32'(j_o[b]), 32'(ej));
                    check($sformatf("k_out[%0d]@%0d", b, k), 32'(k_o[b]), 32'(ek));
                end else begin
                    check($sformatf("ready_done[%0d]", b), 32'(rdy_o[b]), 32'd1);
                    check($sformatf("step_count[%0d]", b), 32'(sc_o[b]), 32'(exp_sc));
                    check($sformatf("err[%0d]", b), 32'(err_o[b]), 32'(exp_err));
                    check($sformatf("bank_q[%0d]", b), 32'(q_bank[b]), 32'(q_final));
                end
            end
            if (k <= lat) begin
                // Requests presented while busy must be ignored.
                drive_req(1'($urandom_range(0, 1)), WIDTH'($urandom), 2'($urandom_range(0, 3)));
                @(negedge CLK);
            end
        end
        drive_req(1'b0, '0, M_LOAD);
        model_q = q_final;
    endtask

    initial begin
        logic [1:0]       m;
        logic [WIDTH-1:0] t;

        reset      = 1'b0;
        stuck0     = '0;
        preset_en  = 1'b1;
        preset_val = '0;
        drive_req(1'b0, '0, M_LOAD);
        repeat (3) @(negedge CLK);
        for (int b = 0; b < N_DUT; b++) begin
            check($sformatf("rst_ready[%0d]", b), 32'(rdy_o[b]), 32'd1);
            check($sformatf("rst_busy[%0d]", b), 32'(busy_o[b]), 32'd0);
            check($sformatf("rst_done[%0d]", b), 32'(done_o[b]), 32'd0);
            check($sformatf("rst_err[%0d]", b), 32'(err_o[b]), 32'd0);
            check($sformatf("rst_sc[%0d]", b), 32'(sc_o[b]), 32'd0);
            check($sformatf("rst_jk[%0d]", b), 32'({j_o[b], k_o[b]}), 32'd0);
        end
        reset     = 1'b1;
        preset_en = 1'b0;
        model_q   = '0;
        @(negedge CLK);

        // Directed cases.
        run_op(M_LOAD, 4'b1010);
        preset(4'b1100);
        run_op(M_LOAD, 4'b1010);
        preset(4'b1110);
        run_op(M_UP, 4'b0001);
        preset(4'b0101);
        run_op(M_DOWN, 4'b0101);
        run_op(M_DOWN, 4'b0010);
        run_op(M_UP, 4'b1111);
        run_op(M_UP, 4'b0000);

        // Stuck-at-0 bank bit 2, then a verify that matches clears err.
        stuck0 = 4'b0100;
        preset(4'b0000);
        run_op(M_LOAD, 4'b0100);
        run_op(M_VERIFY, model_q);
        run_op(M_VERIFY, 4'b0011);
        stuck0 = '0;

        // Reset during the second DRIVE of a step-up.
        preset(4'b0000);
        drive_req(1'b1, 4'b0101, M_UP);
        @(posedge CLK);
        @(negedge CLK);
        drive_req(1'b0, '0, M_LOAD);
        @(negedge CLK);
        @(negedge CLK);
        reset = 1'b0;
        @(negedge CLK);
        reset = 1'b1;
        for (int b = 0; b < N_DUT; b++) begin
            check($sformatf("mid_rst_busy[%0d]", b), 32'(busy_o[b]), 32'd0);
            check($sformatf("mid_rst_ready[%0d]", b), 32'(rdy_o[b]), 32'd1);
            check($sformatf("mid_rst_jk[%0d]", b), 32'({j_o[b], k_o[b]}), 32'd0);
            check($sformatf("mid_rst_sc[%0d]", b), 32'(sc_o[b]), 32'd0);
            check($sformatf("mid_rst_err[%0d]", b), 32'(err_o[b]), 32'd0);
            check($sformatf("mid_rst_done[%0d]", b), 32'(done_o[b]), 32'd0);
        end
        @(negedge CLK);
        for (int b = 0; b < N_DUT; b++) begin
            check($sformatf("post_rst_done[%0d]", b), 32'(done_o[b]), 32'd0);
            check($sformatf("post_rst_bank[%0d]", b), 32'(q_bank[b]), 32'd2);
        end
        model_q = 4'b0010;

        // Randomized requests against the model.
        for (int i = 0; i < 40; i++) begin
            m = 2'($urandom_range(0, 3));
            t = WIDTH'($urandom);
            if (m == M_VERIFY && $urandom_range(0, 1) == 1) t = model_q;
            run_op(m, t);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
